// File: rtl/riscv_core_mem_arb_pkg.sv
// Shared types and constants for the I-cache / D-cache refill read arbiter.
// Policy selection is done in the arbiter via macro RISCV_CORE_RD_ARB_RR_EN.
package riscv_core_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IC = 2'd1,
        GRANT_DC = 2'd2,
        RELEASE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } requester_e;

    localparam int unsigned BLOCK_OFFSET_BITS = 5;
    localparam int unsigned DC_CONSEC_WIDTH   = 4;

    function automatic requester_e other_requester(input requester_e r);
        return (r == REQ_IC) ? REQ_DC : REQ_IC;
    endfunction

endpackage

// File: rtl/riscv_core_mem_read_arbiter.sv
// Arbitrates the single AXI read channel between I-cache and D-cache refills.
// Define RISCV_CORE_RD_ARB_RR_EN for round-robin; default is D-cache priority with IC anti-starvation.
module riscv_core_mem_read_arbiter
    import riscv_core_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned AXI_DATA_WIDTH = 256,
    parameter int unsigned MAX_DC_CONSEC  = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_ic_read_req,
    input  logic [ADDR_WIDTH-1:0]     i_ic_read_addr,
    output logic                      o_ic_read_done,
    input  logic                      i_dc_read_req,
    input  logic [ADDR_WIDTH-1:0]     i_dc_read_addr,
    output logic                      o_dc_read_done,
    output logic [AXI_DATA_WIDTH-1:0] o_read_data,
    output logic                      o_axi_read_req,
    output logic [ADDR_WIDTH-1:0]     o_axi_read_addr,
    input  logic                      i_axi_read_done,
    input  logic [AXI_DATA_WIDTH-1:0] i_axi_read_data
);

    localparam logic [DC_CONSEC_WIDTH-1:0] DcConsecMax = DC_CONSEC_WIDTH'(MAX_DC_CONSEC);

    arb_state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [DC_CONSEC_WIDTH-1:0] dc_consec_q, dc_consec_d;
    requester_e                 rr_ptr_q, rr_ptr_d;

    logic       any_req;
    logic       contended;
    logic       grant_en;
    requester_e winner;

    assign any_req   = i_ic_read_req | i_dc_read_req;
    assign contended = i_ic_read_req & i_dc_read_req;
    assign grant_en  = (state_q == IDLE) && any_req;

    // Arbitration policy: picks the winner and advances policy state only when a grant is made.
    always_comb begin
        winner      = REQ_DC;
        rr_ptr_d    = rr_ptr_q;
        dc_consec_d = dc_consec_q;
`ifdef RISCV_CORE_RD_ARB_RR_EN
        dc_consec_d = '0;
        if (contended) begin
            winner = rr_ptr_q;
            if (grant_en) begin
                rr_ptr_d = other_requester(rr_ptr_q);
            end
        end else if (i_ic_read_req) begin
            winner = REQ_IC;
        end
`else
        // IC wins when alone, or when DC has used up its consecutive-grant allowance.
        if (i_ic_read_req && (!i_dc_read_req || (dc_consec_q == DcConsecMax))) begin
            winner = REQ_IC;
        end
        if (grant_en) begin
            if (winner == REQ_IC) begin
                dc_consec_d = '0;
            end else if (i_ic_read_req && (dc_consec_q != DcConsecMax)) begin
                dc_consec_d = dc_consec_q + 1'b1;
            end
        end
`endif
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        o_axi_read_req = 1'b0;
        o_ic_read_done = 1'b0;
        o_dc_read_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_en) begin
                    if (winner == REQ_IC) begin
                        state_d = GRANT_IC;
                        addr_d  = i_ic_read_addr;
                    end else begin
                        state_d = GRANT_DC;
                        addr_d  = i_dc_read_addr;
                    end
                end
            end
            GRANT_IC: begin
                o_axi_read_req = !i_axi_read_done;
                if (i_axi_read_done) begin
                    // An abandoned refill still completes on AXI but is not reported.
                    o_ic_read_done = i_ic_read_req;
                    state_d        = RELEASE;
                end
            end
            GRANT_DC: begin
                o_axi_read_req = !i_axi_read_done;
                if (i_axi_read_done) begin
                    o_dc_read_done = i_dc_read_req;
                    state_d        = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_axi_read_addr = addr_q;
    assign o_read_data     = i_axi_read_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            dc_consec_q <= '0;
            rr_ptr_q    <= REQ_DC;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            dc_consec_q <= dc_consec_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

`ifndef SYNTHESIS
    done_exclusive_a : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(o_ic_read_done && o_dc_read_done));

    consec_bound_a : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        dc_consec_q <= DcConsecMax);

    ic_done_owner_a : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        o_ic_read_done |-> (state_q == GRANT_IC));

    dc_done_owner_a : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        o_dc_read_done |-> (state_q == GRANT_DC));
`endif

endmodule

// File: tb/tb_riscv_core_mem_read_arbiter.sv
// Directed self-checking bench for riscv_core_mem_read_arbiter (policy follows RISCV_CORE_RD_ARB_RR_EN).
module tb_riscv_core_mem_read_arbiter;

    localparam int AW = 64;
    localparam int DW = 256;
    localparam int NG = 10;
    localparam logic [DW-1:0] LINE1 = {4{64'hDEAD_BEEF_0123_4567}};
    localparam logic [DW-1:0] LINE2 = {4{64'h0F0F_A5A5_5A5A_F0F0}};
    localparam logic [AW-1:0] IC_A  = 64'h0000_0000_0000_A000;
    localparam logic [AW-1:0] DC_A  = 64'h0000_0000_0000_B000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ic_req = 1'b0;
    logic [AW-1:0] ic_addr = '0;
    logic          dc_req = 1'b0;
    logic [AW-1:0] dc_addr = '0;
    logic          axi_done = 1'b0;
    logic [DW-1:0] axi_data = '0;
    logic          ic_done, dc_done, axi_req;
    logic [AW-1:0] axi_addr;
    logic [DW-1:0] read_data;

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;

    riscv_core_mem_read_arbiter dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_ic_read_req   (ic_req),
        .i_ic_read_addr  (ic_addr),
        .o_ic_read_done  (ic_done),
        .i_dc_read_req   (dc_req),
        .i_dc_read_addr  (dc_addr),
        .o_dc_read_done  (dc_done),
        .o_read_data     (read_data),
        .o_axi_read_req  (axi_req),
        .o_axi_read_addr (axi_addr),
        .i_axi_read_done (axi_done),
        .i_axi_read_data (axi_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          ic_req;
        logic [AW-1:0] ic_addr;
        logic          dc_req;
        logic [AW-1:0] dc_addr;
        logic          done;
        logic [DW-1:0] data;
        logic          e_req;
        logic [AW-1:0] e_addr;
        logic          e_ic;
        logic          e_dc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(input logic icr, input logic [AW-1:0] ica, input logic dcr,
                                 input logic [AW-1:0] dca, input logic dn, input logic [DW-1:0] dat,
                                 input logic er, input logic [AW-1:0] ea, input logic eic,
                                 input logic edc);
        vec_t v;
        v.ic_req = icr; v.ic_addr = ica; v.dc_req = dcr; v.dc_addr = dca;
        v.done = dn; v.data = dat; v.e_req = er; v.e_addr = ea; v.e_ic = eic; v.e_dc = edc;
        return v;
    endfunction

    task automatic drive(input logic icr, input logic [AW-1:0] ica, input logic dcr,
                         input logic [AW-1:0] dca, input logic dn, input logic [DW-1:0] dat);
        @(negedge clk);
        ic_req = icr; ic_addr = ica; dc_req = dcr; dc_addr = dca;
        axi_done = dn; axi_data = dat;
        #1;
    endtask

    task automatic chk(input string nm, input logic e_req, input logic [AW-1:0] e_addr,
                       input logic e_ic, input logic e_dc, input logic e_chk_data,
                       input logic [DW-1:0] e_data);
        logic bad;
        bad = (axi_req !== e_req) || (axi_addr !== e_addr) || (ic_done !== e_ic) ||
              (dc_done !== e_dc) || (e_chk_data && (read_data !== e_data));
        n_vec++;
        if (bad) begin
            n_fail++;
            $display("FAIL %s: got req=%b addr=%h ic_done=%b dc_done=%b data=%h; want req=%b addr=%h ic_done=%b dc_done=%b data=%h",
                     nm, axi_req, axi_addr, ic_done, dc_done, read_data,
                     e_req, e_addr, e_ic, e_dc, e_data);
        end
    endtask

    logic exp_ic [NG];

    initial begin
        // Table: DC-only refill, address hold, spurious done in IDLE/RELEASE, IC-only refill.
        tbl.push_back(mkv(0, 0,     0, 0,        0, 0,     0, 0,        0, 0));
        tbl.push_back(mkv(0, 0,     1, 64'h1000_0040, 0, 0, 0, 0,       0, 0));
        tbl.push_back(mkv(0, 0,     1, 64'h1000_0040, 0, 0, 1, 64'h1000_0040, 0, 0));
        tbl.push_back(mkv(0, 0,     1, 64'h1000_0140, 0, 0, 1, 64'h1000_0040, 0, 0));
        tbl.push_back(mkv(0, 0,     1, 64'h1000_0040, 0, 0, 1, 64'h1000_0040, 0, 0));
        tbl.push_back(mkv(0, 0,     1, 64'h1000_0040, 0, 0, 1, 64'h1000_0040, 0, 0));
        tbl.push_back(mkv(0, 0,     1, 64'h1000_0040, 0, 0, 1, 64'h1000_0040, 0, 0));
        tbl.push_back(mkv(0, 0,     1, 64'h1000_0040, 1, LINE1, 0, 64'h1000_0040, 0, 1));
        tbl.push_back(mkv(0, 0,     0, 0,        0, 0,     0, 64'h1000_0040, 0, 0));
        tbl.push_back(mkv(0, 0,     0, 0,        0, 0,     0, 64'h1000_0040, 0, 0));
        tbl.push_back(mkv(0, 0,     0, 0,        1, LINE2, 0, 64'h1000_0040, 0, 0));
        tbl.push_back(mkv(0, 0,     1, 64'h40,   0, 0,     0, 64'h1000_0040, 0, 0));
        tbl.push_back(mkv(0, 0,     1, 64'h40,   0, 0,     1, 64'h40,   0, 0));
        tbl.push_back(mkv(0, 0,     1, 64'h40,   1, LINE2, 0, 64'h40,   0, 1));
        tbl.push_back(mkv(0, 0,     1, 64'h40,   1, LINE1, 0, 64'h40,   0, 0));
        tbl.push_back(mkv(0, 0,     0, 0,        0, 0,     0, 64'h40,   0, 0));
        tbl.push_back(mkv(1, 64'hC0, 0, 0,       0, 0,     0, 64'h40,   0, 0));
        tbl.push_back(mkv(1, 64'hC0, 0, 0,       0, 0,     1, 64'hC0,   0, 0));
        tbl.push_back(mkv(1, 64'hC0, 0, 0,       1, LINE1, 0, 64'hC0,   1, 0));
        tbl.push_back(mkv(0, 0,     0, 0,        0, 0,     0, 64'hC0,   0, 0));

`ifdef RISCV_CORE_RD_ARB_RR_EN
        exp_ic = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_ic = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].ic_req, tbl[i].ic_addr, tbl[i].dc_req, tbl[i].dc_addr,
                  tbl[i].done, tbl[i].data);
            chk($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_ic, tbl[i].e_dc,
                tbl[i].e_ic | tbl[i].e_dc, tbl[i].data);
        end

        // Abandon: IC drops req mid-transfer; done swallowed; next grant two cycles after done.
        drive(1, 64'h2000, 0, 0, 0, 0);       chk("abn_idle", 0, 64'hC0, 0, 0, 0, 0);
        drive(1, 64'h2000, 0, 0, 0, 0);       chk("abn_grant", 1, 64'h2000, 0, 0, 0, 0);
        drive(0, 64'h2000, 0, 0, 0, 0);       chk("abn_drop", 1, 64'h2000, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);              chk("abn_hold", 1, 64'h2000, 0, 0, 0, 0);
        drive(0, 0, 1, 64'h3000, 1, LINE1);   chk("abn_done", 0, 64'h2000, 0, 0, 0, 0);
        drive(0, 0, 1, 64'h3000, 0, 0);       chk("abn_rel", 0, 64'h2000, 0, 0, 0, 0);
        drive(0, 0, 1, 64'h3000, 0, 0);       chk("abn_idle2", 0, 64'h2000, 0, 0, 0, 0);
        drive(0, 0, 1, 64'h3000, 0, 0);       chk("abn_regrant", 1, 64'h3000, 0, 0, 0, 0);
        drive(0, 0, 1, 64'h3000, 1, LINE2);   chk("abn_dcdone", 0, 64'h3000, 0, 1, 1, LINE2);
        drive(0, 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a DC grant.
        drive(0, 0, 1, 64'h5000, 0, 0);
        drive(0, 0, 1, 64'h5000, 0, 0);       chk("rst_pre", 1, 64'h5000, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;                                   chk("rst_async", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;                                   chk("rst_rel", 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 64'h5000, 0, 0);       chk("rst_regrant", 1, 64'h5000, 0, 0, 0, 0);
        drive(0, 0, 1, 64'h5000, 1, LINE1);   chk("rst_done", 0, 64'h5000, 0, 1, 1, LINE1);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);

        // Contention: both requesters re-raise after each completion.
        begin
            int last_rise;
            last_rise = -1;
            drive(1, IC_A, 1, DC_A, 0, 0);
            for (int g = 0; g < NG; g++) begin
                int waited;
                logic [DW-1:0] line;
                waited = 0;
                while (!axi_req && waited < 10) begin
                    @(negedge clk);
                    #1;
                    waited++;
                end
                if (!axi_req) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL cont%0d_timeout: got req=%b after %0d cycles; want req=1",
                             g, axi_req, waited);
                    break;
                end
                chk($sformatf("cont%0d_owner", g), 1, exp_ic[g] ? IC_A : DC_A, 0, 0, 0, 0);
                if (last_rise >= 0) begin
                    n_vec++;
                    if ((cyc - last_rise) != 4) begin
                        n_fail++;
                        $display("FAIL cont%0d_spacing: got %0d cycles; want 4",
                                 g, cyc - last_rise);
                    end
                end
                last_rise = cyc;
                line = {8{32'h1234_0000 + 32'(g)}};
                drive(1, IC_A, 1, DC_A, 1, line);
                chk($sformatf("cont%0d_done", g), 0, exp_ic[g] ? IC_A : DC_A,
                    exp_ic[g], !exp_ic[g], 1, line);
                drive(!exp_ic[g], IC_A, exp_ic[g], DC_A, 0, 0);
                drive(1, IC_A, 1, DC_A, 0, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
